axis_cfg_sched: RTL and testbench

AXIS_CFG_SCHED -- requirements
Module: axis_cfg_sched

---
 rtl/axis_cfg_sched.sv | 176 +++++++++++++++++
 tb/tb_axis_cfg_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_cfg_sched.sv
// Round-robin descriptor scheduler: grants one requester, then emits ID/ADDR/LEN config beats and a gap.
// Optional feature macro: AXIS_CFG_SCHED_ZERO_LEN_DROP_EN (zero-length descriptors skip their beats).
module axis_cfg_sched #(
    parameter int NUM_REQ       = 2,
    parameter int CONFIG_ADDR   = 23,
    parameter int CONFIG_DATA   = 24,
    parameter int CONFIG_AWIDTH = 5,
    parameter int CONFIG_DWIDTH = 32,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*CONFIG_DWIDTH-1:0] req_id,
    input  logic [NUM_REQ*CONFIG_DWIDTH-1:0] req_address,
    input  logic [NUM_REQ*CONFIG_DWIDTH-1:0] req_length,
    input  logic                             cfg_hold,
    output logic [CONFIG_AWIDTH-1:0]         cfg_addr,
    output logic [CONFIG_DWIDTH-1:0]         cfg_data,
    output logic                             cfg_valid,
    output logic                             busy
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 1) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_ID   = 5'b00010,
        S_ADDR = 5'b00100,
        S_LEN  = 5'b01000,
        S_GAP  = 5'b10000
    } state_t;

    state_t                     state_q, state_d;
    logic [PW-1:0]              ptr_q, ptr_d;
    logic [3:0]                 gap_cnt_q, gap_cnt_d;
    logic [CONFIG_DWIDTH-1:0]   id_q, id_d, addr_q, addr_d, len_q, len_d;
    logic [NUM_REQ-1:0]         req_ready_q, req_ready_d;
    logic                       cfg_valid_q, cfg_valid_d;
    logic [CONFIG_AWIDTH-1:0]   cfg_addr_q, cfg_addr_d;
    logic [CONFIG_DWIDTH-1:0]   cfg_data_q, cfg_data_d;
    logic                       busy_q, busy_d;
    logic                       found_s;
    logic [PW-1:0]              gnt_idx_s;

    // Round-robin search for the first valid requester at or after the pointer
    always_comb begin
        int idx;
        idx       = 0;
        found_s   = 1'b0;
        gnt_idx_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!found_s && req_valid[idx]) begin
                found_s   = 1'b1;
                gnt_idx_s = PW'(idx);
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Next-state and next-output logic; bus outputs lag the state by one cycle
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gap_cnt_d   = gap_cnt_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        req_ready_d = '0;
        cfg_valid_d = 1'b0;
        cfg_addr_d  = '0;
        cfg_data_d  = '0;
        busy_d      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (!cfg_hold && found_s) begin
                    req_ready_d[gnt_idx_s] = 1'b1;
                    id_d    = req_id[int'(gnt_idx_s)*CONFIG_DWIDTH +: CONFIG_DWIDTH];
                    addr_d  = req_address[int'(gnt_idx_s)*CONFIG_DWIDTH +: CONFIG_DWIDTH];
                    len_d   = req_length[int'(gnt_idx_s)*CONFIG_DWIDTH +: CONFIG_DWIDTH];
                    state_d = S_ID;
                    if (int'(gnt_idx_s) == NUM_REQ - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gnt_idx_s + PW'(1);
                    end
`ifdef AXIS_CFG_SCHED_ZERO_LEN_DROP_EN
                    if (req_length[int'(gnt_idx_s)*CONFIG_DWIDTH +: CONFIG_DWIDTH] == '0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end else begin
                        state_d   = S_ID;
                    end
`else
                    gap_cnt_d = gap_cnt_q;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ID: begin
                cfg_valid_d = 1'b1;
                cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_ADDR);
                cfg_data_d  = id_q;
                state_d     = S_ADDR;
            end
            S_ADDR: begin
                cfg_valid_d = 1'b1;
                cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_DATA);
                cfg_data_d  = addr_q;
                state_d     = S_LEN;
            end
            S_LEN: begin
                cfg_valid_d = 1'b1;
                cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_DATA);
                cfg_data_d  = len_q;
                state_d     = S_GAP;
                gap_cnt_d   = GAP_LOAD;
            end
            S_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, descriptor capture and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gap_cnt_q   <= 4'd0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            req_ready_q <= '0;
            cfg_valid_q <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gap_cnt_q   <= gap_cnt_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            req_ready_q <= req_ready_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign cfg_valid = cfg_valid_q;
    assign cfg_addr  = cfg_addr_q;
    assign cfg_data  = cfg_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_axis_cfg_sched.sv
// Self-checking bench for axis_cfg_sched: directed vector table, corner sequences, random run vs. transaction model.
module tb_axis_cfg_sched;
    localparam int N  = 2;
    localparam int W  = 32;
    localparam int AW = 5;
    localparam int G  = 2;
    localparam int NC = 1500;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*W-1:0]  req_id, req_address, req_length;
    logic            cfg_hold;
    logic [AW-1:0]   cfg_addr;
    logic [W-1:0]    cfg_data;
    logic            cfg_valid, busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    axis_cfg_sched #(.NUM_REQ(N), .CONFIG_ADDR(23), .CONFIG_DATA(24), .CONFIG_AWIDTH(AW),
                     .CONFIG_DWIDTH(W), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_address(req_address), .req_length(req_length),
        .cfg_hold(cfg_hold), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                  g;
        logic [W-1:0]        id, addr, len;
        logic [2:0][AW-1:0]  ea;
        logic [2:0][W-1:0]   ed;
        int                  nbeats;
        int                  idle_at;
    } vec_t;

    vec_t vt[4];

    logic [N-1:0]  e_ready[NC+16];
    logic          e_valid[NC+16];
    logic [AW-1:0] e_addr[NC+16];
    logic [W-1:0]  e_data[NC+16];
    logic          e_busy[NC+16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int g, input logic [W-1:0] id, input logic [W-1:0] ad, input logic [W-1:0] ln);
        req_id[g*W +: W]      = id;
        req_address[g*W +: W] = ad;
        req_length[g*W +: W]  = ln;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'd0);
        step();
    endtask

    function automatic vec_t mkv(input int g, input logic [W-1:0] id, input logic [W-1:0] ad,
                                 input logic [W-1:0] ln, input int nb, input int ia);
        vec_t v;
        v.g = g; v.id = id; v.addr = ad; v.len = ln;
        v.ea = {5'd24, 5'd24, 5'd23};
        v.ed = {ln, ad, id};
        v.nbeats = nb; v.idle_at = ia;
        return v;
    endfunction

    initial begin
        logic [N-1:0] exp_r;
        int ng, free_at, rr, g, gl, nb;
        logic [W-1:0] mid, mad, mln;

        vt[0] = mkv(0, 32'd1, 32'h0000_1000, 32'd64, 3, 6);
        vt[1] = mkv(1, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 3, 6);
`ifdef AXIS_CFG_SCHED_ZERO_LEN_DROP_EN
        vt[2] = mkv(0, 32'd5, 32'h0000_0040, 32'd0, 0, 3);
`else
        vt[2] = mkv(0, 32'd5, 32'h0000_0040, 32'd0, 3, 6);
`endif
        vt[3] = mkv(1, 32'd7, 32'h0000_0020, 32'd1, 3, 6);

        rst_n = 1'b0; req_valid = '0; req_id = '0; req_address = '0; req_length = '0; cfg_hold = 1'b0;
        #2;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_valid", 64'(cfg_valid), 64'd0);
        check("rst_addr", 64'(cfg_addr), 64'd0);
        check("rst_data", 64'(cfg_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Directed single-descriptor table
        foreach (vt[i]) begin
            set_req(vt[i].g, vt[i].id, vt[i].addr, vt[i].len);
            req_valid = N'(1) << vt[i].g;
            step();
            check("tbl_ready", 64'(req_ready), 64'(N'(1) << vt[i].g));
            req_valid = '0;
            set_req(vt[i].g, ~vt[i].id, ~vt[i].addr, ~vt[i].len);
            for (int t = 1; t <= 6; t++) begin
                step();
                check("tbl_valid", 64'(cfg_valid), 64'(t <= vt[i].nbeats));
                if (t <= vt[i].nbeats) begin
                    check("tbl_addr", 64'(cfg_addr), 64'(vt[i].ea[t-1]));
                    check("tbl_data", 64'(cfg_data), 64'(vt[i].ed[t-1]));
                end else begin
                    check("tbl_idle_bus", 64'({cfg_addr, cfg_data}), 64'd0);
                end
                check("tbl_busy", 64'(busy), 64'(t < vt[i].idle_at));
                check("tbl_ready_pulse", 64'(req_ready), 64'd0);
            end
            wait_idle();
        end

        // Round robin with both requesters held
        set_req(0, 32'hA0, 32'h100, 32'h10);
        set_req(1, 32'hB1, 32'h200, 32'h20);
        req_valid = 2'b11;
        ng = 0;
        for (int cyc = 0; cyc < 60 && ng < 4; cyc++) begin
            step();
            if (req_ready != '0) begin
                check("rr_grant", 64'(req_ready), 64'(2'b01 << (ng % 2)));
                if (ng == 3) req_valid = '0;
                step();
                check("rr_id_valid", 64'(cfg_valid), 64'd1);
                check("rr_id_data", 64'(cfg_data), (ng % 2 == 0) ? 64'hA0 : 64'hB1);
                step();
                check("rr_addr_valid", 64'(cfg_valid), 64'd1);
                step();
                check("rr_len_valid", 64'(cfg_valid), 64'd1);
                ng++;
            end
        end
        check("rr_count", 64'(ng), 64'd4);
        req_valid = '0;
        wait_idle();

        // Hold blocks grants, release grants next cycle
        cfg_hold = 1'b1;
        req_valid = 2'b10;
        for (int t = 0; t < 10; t++) begin
            step();
            check("hold_no_grant", 64'(req_ready), 64'd0);
        end
        cfg_hold = 1'b0;
        step();
        check("hold_release", 64'(req_ready), 64'd2);
        req_valid = '0;
        cfg_hold = 1'b1;
        step();
        check("hold_mid_id", 64'(cfg_valid), 64'd1);
        step();
        step();
        check("hold_mid_len", 64'({cfg_valid, cfg_data}), {31'd0, 1'b1, 32'h20});
        cfg_hold = 1'b0;
        wait_idle();

        // Input change right after grant does not affect beats
        set_req(1, 32'h11, 32'hAAAA_0000, 32'h33);
        req_valid = 2'b10;
        step();
        check("cap_ready", 64'(req_ready), 64'd2);
        req_valid = '0;
        set_req(1, 32'h99, 32'h5555_0000, 32'h77);
        step();
        check("cap_id", 64'(cfg_data), 64'h11);
        step();
        check("cap_addr", 64'(cfg_data), 64'hAAAA_0000);
        step();
        check("cap_len", 64'(cfg_data), 64'h33);
        wait_idle();

        // Reset during the ADDR beat aborts the descriptor
        set_req(0, 32'h3, 32'h4000, 32'h8);
        req_valid = 2'b01;
        step();
        check("rstmid_ready", 64'(req_ready), 64'd1);
        req_valid = '0;
        step();
        step();
        check("rstmid_addr_beat", 64'({cfg_valid, cfg_addr}), {58'd0, 1'b1, 5'd24});
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", 64'(cfg_valid), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        step();
        rst_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            step();
            check("rstmid_no_beat", 64'({cfg_valid, busy}), 64'd0);
        end
        req_valid = 2'b01;
        step();
        check("rstmid_regrant", 64'(req_ready), 64'd1);
        req_valid = '0;
        wait_idle();

        // Random run against a transaction-level model
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < NC + 16; c++) begin
            e_ready[c] = '0; e_valid[c] = 1'b0; e_addr[c] = '0; e_data[c] = '0; e_busy[c] = 1'b0;
        end
        free_at = 0;
        rr = 0;
        gl = (G < 1) ? 1 : G;
        for (int c = 0; c < NC; c++) begin
            req_valid = N'($urandom_range(0, 3));
            cfg_hold  = ($urandom_range(0, 5) == 0);
            for (int r = 0; r < N; r++) begin
                set_req(r, $urandom, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            end
            @(posedge clk);
            if (c >= free_at && !cfg_hold && req_valid != '0) begin
                g = rr;
                while (!req_valid[g]) g = (g + 1) % N;
                rr = (g + 1) % N;
                mid = req_id[g*W +: W];
                mad = req_address[g*W +: W];
                mln = req_length[g*W +: W];
                e_ready[c] = N'(1) << g;
                nb = 3;
`ifdef AXIS_CFG_SCHED_ZERO_LEN_DROP_EN
                if (mln == '0) nb = 0;
`endif
                if (nb == 3) begin
                    e_valid[c+1] = 1'b1; e_addr[c+1] = 5'd23; e_data[c+1] = mid;
                    e_valid[c+2] = 1'b1; e_addr[c+2] = 5'd24; e_data[c+2] = mad;
                    e_valid[c+3] = 1'b1; e_addr[c+3] = 5'd24; e_data[c+3] = mln;
                    for (int k = c + 1; k <= c + 3 + gl; k++) e_busy[k] = 1'b1;
                    free_at = c + 4 + gl;
                end else begin
                    for (int k = c + 1; k <= c + gl; k++) e_busy[k] = 1'b1;
                    free_at = c + 1 + gl;
                end
            end
            #1;
            exp_r = e_ready[c];
            check("rnd_ready", 64'(req_ready), 64'(exp_r));
            check("rnd_valid", 64'(cfg_valid), 64'(e_valid[c]));
            check("rnd_addr", 64'(cfg_addr), 64'(e_addr[c]));
            check("rnd_data", 64'(cfg_data), 64'(e_data[c]));
            check("rnd_busy", 64'(busy), 64'(e_busy[c]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
